hdmi_island_scheduler: RTL

//  Schedules HDMI data islands inside horizontal blanking and grants packet slots to up to four packet sources.

---
 rtl/hdmi_island_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/hdmi_island_scheduler.sv
// Places at most one HDMI data island per line inside horizontal blanking and
// hands its packet slots to four sources in fixed priority order.
module hdmi_island_scheduler #(
  parameter logic HS_ACTIVE = 1'b1,
  parameter int   PREAMBLE  = 8,
  parameter int   GUARD     = 2,
  parameter int   PKT_LEN   = 32,
  parameter int   MAX_PKTS  = 2
) (
  input  logic       i_pixclk,
  input  logic       i_reset,
  input  logic       i_hSync,
  input  logic       i_blank,
  input  logic       i_enable,
  input  logic [3:0] i_req,
  output logic [3:0] o_ack,
  output logic [1:0] o_sel,
  output logic       o_pkt_active,
  output logic       o_pkt_first,
  output logic [4:0] o_pkt_idx,
  output logic       o_preamble,
  output logic       o_guard,
  output logic       o_island,
  output logic       o_abort
);

  localparam logic [4:0] PRE_LAST    = 5'(PREAMBLE - 1);
  localparam logic [4:0] GUARD_LAST  = 5'(GUARD - 1);
  localparam logic [4:0] IDX_LAST    = 5'(PKT_LEN - 1);
  localparam logic [4:0] IDX_PRELAST = 5'(PKT_LEN - 2);
  localparam logic [4:0] MAX_CNT     = 5'(MAX_PKTS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    LGUARD = 3'd2,
    PKT    = 3'd3,
    TGUARD = 3'd4
  } state_t;

  state_t     state_r;
  logic [4:0] phaseCnt_r;
  logic [4:0] pktCnt_r;
  logic       hsQ_r;
  logic       blankQ_r;
  logic       armed_r;

  logic       startHit_s;
  logic       blankFall_s;
  logic       moreWanted_s;
  logic [3:0] reqMasked_s;

  function automatic logic [1:0] prioIdx(input logic [3:0] req);
    if (req[0])      return 2'd0;
    else if (req[1]) return 2'd1;
    else if (req[2]) return 2'd2;
    else             return 2'd3;
  endfunction

  assign startHit_s   = (state_r == IDLE) && (i_hSync == HS_ACTIVE) && (hsQ_r != HS_ACTIVE) &&
                        i_blank && i_enable && armed_r && (|i_req);
  assign blankFall_s  = blankQ_r & ~i_blank;
  // The source acked this cycle may still show its request; keep it out of the next grant.
  assign reqMasked_s  = i_req & ~(4'b0001 << o_sel);
  assign moreWanted_s = (pktCnt_r < MAX_CNT) && (|reqMasked_s);

  // Island sequencer with all timing outputs registered.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state_r      <= IDLE;
      phaseCnt_r   <= 5'd0;
      pktCnt_r     <= 5'd0;
      hsQ_r        <= 1'b0;
      blankQ_r     <= 1'b0;
      armed_r      <= 1'b0;
      o_ack        <= 4'b0000;
      o_sel        <= 2'd0;
      o_pkt_active <= 1'b0;
      o_pkt_first  <= 1'b0;
      o_pkt_idx    <= 5'd0;
      o_preamble   <= 1'b0;
      o_guard      <= 1'b0;
      o_island     <= 1'b0;
      o_abort      <= 1'b0;
    end else begin
      hsQ_r       <= i_hSync;
      blankQ_r    <= i_blank;
      o_ack       <= 4'b0000;
      o_abort     <= 1'b0;
      o_pkt_first <= 1'b0;

      if (startHit_s)       armed_r <= 1'b0;
      else if (blankFall_s) armed_r <= 1'b1;

      if ((state_r != IDLE) && blankFall_s) begin
        state_r      <= IDLE;
        phaseCnt_r   <= 5'd0;
        pktCnt_r     <= 5'd0;
        o_sel        <= 2'd0;
        o_pkt_active <= 1'b0;
        o_pkt_idx    <= 5'd0;
        o_preamble   <= 1'b0;
        o_guard      <= 1'b0;
        o_island     <= 1'b0;
        o_abort      <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            if (startHit_s) begin
              state_r    <= PRE;
              phaseCnt_r <= 5'd0;
              pktCnt_r   <= 5'd1;
              o_sel      <= prioIdx(i_req);
              o_preamble <= 1'b1;
              o_island   <= 1'b1;
            end
          end
          PRE: begin
            if (phaseCnt_r == PRE_LAST) begin
              state_r    <= LGUARD;
              phaseCnt_r <= 5'd0;
              o_preamble <= 1'b0;
              o_guard    <= 1'b1;
            end else begin
              phaseCnt_r <= phaseCnt_r + 5'd1;
            end
          end
          LGUARD: begin
            if (phaseCnt_r == GUARD_LAST) begin
              state_r      <= PKT;
              phaseCnt_r   <= 5'd0;
              o_guard      <= 1'b0;
              o_pkt_active <= 1'b1;
              o_pkt_first  <= 1'b1;
              o_pkt_idx    <= 5'd0;
            end else begin
              phaseCnt_r <= phaseCnt_r + 5'd1;
            end
          end
          PKT: begin
            if (o_pkt_idx == IDX_LAST) begin
              if (moreWanted_s) begin
                o_pkt_idx   <= 5'd0;
                o_pkt_first <= 1'b1;
                o_sel       <= prioIdx(reqMasked_s);
                pktCnt_r    <= pktCnt_r + 5'd1;
              end else begin
                state_r      <= TGUARD;
                phaseCnt_r   <= 5'd0;
                o_pkt_active <= 1'b0;
                o_pkt_idx    <= 5'd0;
                o_sel        <= 2'd0;
                o_guard      <= 1'b1;
              end
            end else begin
              o_pkt_idx <= o_pkt_idx + 5'd1;
              // Registered ack lands on the packet's last period.
              if (o_pkt_idx == IDX_PRELAST) o_ack <= 4'b0001 << o_sel;
            end
          end
          TGUARD: begin
            if (phaseCnt_r == GUARD_LAST) begin
              state_r    <= IDLE;
              phaseCnt_r <= 5'd0;
              pktCnt_r   <= 5'd0;
              o_guard    <= 1'b0;
              o_island   <= 1'b0;
            end else begin
              phaseCnt_r <= phaseCnt_r + 5'd1;
            end
          end
          default: begin
            state_r      <= IDLE;
            phaseCnt_r   <= 5'd0;
            pktCnt_r     <= 5'd0;
            o_pkt_active <= 1'b0;
            o_preamble   <= 1'b0;
            o_guard      <= 1'b0;
            o_island     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
